// File: rtl/ext_mem_responder.sv
// Purpose : single-port DEPTH x DATA_W memory target for the CPU external bus, with a side loader port.
// Latency : ready pulse WAIT_STATES+2 cycles after the accept cycle (accept, WAIT_STATES waits, access, ready).
// Backpress: one request at a time; i_mem_req is sampled only in IDLE, loader writes ignored while o_load_busy.
//
// Ports:
//   i_clk / i_rst_n                    clock (rising edge) and synchronous active-low reset
//   i_mem_req / i_mem_we               CPU request strobe and direction (1 = write), latched on accept
//   i_memory_addr / i_memory_data      CPU word address and write data
//   o_memory_data / o_mem_ready        registered read data (held until next read) and 1-cycle completion pulse
//   i_load_we / i_load_addr / i_load_data  loader write port, honoured only in IDLE, wins over i_mem_req
//   o_load_busy                        high whenever a CPU transaction is in progress
//   o_mem_fault                        (MEM_WRITE_PROTECT_EN only) pulses with o_mem_ready on a blocked write
//
// Optional feature macro: MEM_WRITE_PROTECT_EN -- CPU writes below PROTECT_TOP complete but do not commit.

module ext_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
`ifdef MEM_WRITE_PROTECT_EN
  ,
  parameter logic [ADDR_W-1:0] PROTECT_TOP = 'h40
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_memory_addr,
  input  logic [DATA_W-1:0] i_memory_data,
  output logic [DATA_W-1:0] o_memory_data,
  output logic              o_mem_ready,
  input  logic              i_load_we,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
`ifdef MEM_WRITE_PROTECT_EN
  output logic              o_mem_fault,
`endif
  output logic              o_load_busy
);

  localparam int IDX_W = $clog2(DEPTH);
  // Last counter value spent in WAIT; unused when WAIT_STATES is 0 (WAIT is skipped).
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_wr;
  logic [IDX_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              cpu_commit;

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!i_load_we && i_mem_req) state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt_q == WS_LAST) state_d = S_ACCESS;
      S_ACCESS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef MEM_WRITE_PROTECT_EN
  assign cpu_commit = (addr_q >= PROTECT_TOP);
`else
  assign cpu_commit = 1'b1;
`endif

  // Outputs and datapath next-state.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    fault_d = 1'b0;
    mem_wr  = 1'b0;
    mem_wa  = addr_q[IDX_W-1:0];
    mem_wd  = wdata_q;
    case (state_q)
      S_IDLE: begin
        // Loader has priority; a colliding CPU request simply stays pending.
        if (i_load_we) begin
          mem_wr = 1'b1;
          mem_wa = i_load_addr[IDX_W-1:0];
          mem_wd = i_load_data;
        end else if (i_mem_req) begin
          addr_d  = i_memory_addr;
          we_d    = i_mem_we;
          wdata_d = i_memory_data;
          cnt_d   = '0;
        end
      end
      S_WAIT: cnt_d = cnt_q + 4'd1;
      S_ACCESS: begin
        ready_d = 1'b1;
        if (we_q) begin
          mem_wr  = cpu_commit;
          fault_d = !cpu_commit;
        end else begin
          rdata_d = mem[addr_q[IDX_W-1:0]];
        end
      end
      default: ;
    endcase
  end

  // Memory contents survive reset; writes are only blocked while reset is asserted.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && mem_wr) mem[mem_wa] <= mem_wd;
  end

  assign o_memory_data = rdata_q;
  assign o_mem_ready   = ready_q;
  assign o_load_busy   = (state_q != S_IDLE);
`ifdef MEM_WRITE_PROTECT_EN
  assign o_mem_fault   = fault_q;
`endif

endmodule
